// File: rtl/riscv_ahb3_mem_responder.sv
// riscv_ahb3_mem_responder: NPORTS-port AHB3 slave sharing one word-addressed memory.
// Optional build macro AHB3_ERR_INJECT_EN adds the err_inject input that forces ERROR responses.
module riscv_ahb3_mem_responder #(
    parameter int XLEN      = 64,
    parameter int PLEN      = 64,
    parameter int NPORTS    = 2,
    parameter int MEM_BYTES = 4096,
    parameter int WAIT_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        HSEL,
    input  logic [NPORTS*PLEN-1:0]   HADDR,
    input  logic [NPORTS*XLEN-1:0]   HWDATA,
    output logic [NPORTS*XLEN-1:0]   HRDATA,
    input  logic [NPORTS-1:0]        HWRITE,
    input  logic [NPORTS*3-1:0]      HSIZE,
    input  logic [NPORTS*3-1:0]      HBURST,
    input  logic [NPORTS*4-1:0]      HPROT,
    input  logic [NPORTS*2-1:0]      HTRANS,
    input  logic [NPORTS-1:0]        HMASTLOCK,
    output logic [NPORTS-1:0]        HREADY,
    output logic [NPORTS-1:0]        HRESP,
    input  logic [NPORTS*WAIT_W-1:0] wait_cfg
`ifdef AHB3_ERR_INJECT_EN
    ,
    input  logic [NPORTS-1:0]        err_inject
`endif
);
    localparam int BW    = XLEN / 8;
    localparam int AW    = $clog2(BW);
    localparam int MW    = $clog2(MEM_BYTES);
    localparam int DEPTH = MEM_BYTES / BW;
    localparam logic [2:0] MAX_SIZE = 3'(AW);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    logic [XLEN-1:0]   r_mem   [DEPTH];
    state_t            r_state [NPORTS];
    logic [MW-1:0]     r_addr  [NPORTS];
    logic              r_write [NPORTS];
    logic [2:0]        r_size  [NPORTS];
    logic [WAIT_W-1:0] r_wcnt  [NPORTS];
    logic [XLEN-1:0]   r_rdata [NPORTS];

    state_t            w_next  [NPORTS];
    logic [PLEN-1:0]   w_addr  [NPORTS];
    logic [2:0]        w_size  [NPORTS];
    logic [WAIT_W-1:0] w_wcfg  [NPORTS];
    logic [XLEN-1:0]   w_word  [NPORTS];
    logic [BW-1:0]     w_be    [NPORTS];
    logic              w_acc   [NPORTS];
    logic              w_bad   [NPORTS];
    logic [NPORTS-1:0] w_inj;
    logic              w_unused;

`ifdef AHB3_ERR_INJECT_EN
    assign w_inj = err_inject;
`else
    assign w_inj = '0;
`endif

    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS};

    // Per-port acceptance, error classification, next state and bus outputs
    always_comb begin
        HREADY = '0;
        HRESP  = '0;
        HRDATA = '0;
        w_next = '{default: S_IDLE};
        w_addr = '{default: '0};
        w_size = '{default: '0};
        w_wcfg = '{default: '0};
        w_word = '{default: '0};
        w_be   = '{default: '0};
        w_acc  = '{default: 1'b0};
        w_bad  = '{default: 1'b0};
        for (int p = 0; p < NPORTS; p++) begin
            w_addr[p] = HADDR[p*PLEN +: PLEN];
            w_size[p] = HSIZE[p*3 +: 3];
            w_wcfg[p] = wait_cfg[p*WAIT_W +: WAIT_W];
            w_word[p] = r_mem[r_addr[p][MW-1:AW]];
            HREADY[p] = (r_state[p] != S_WAIT) && (r_state[p] != S_ERR1);
            HRESP[p]  = (r_state[p] == S_ERR1) || (r_state[p] == S_ERR2);
            HRDATA[p*XLEN +: XLEN] = (r_state[p] == S_DATA && !r_write[p]) ? w_word[p] : r_rdata[p];
            w_acc[p]  = HSEL[p] && HTRANS[p*2+1] && (r_state[p] != S_WAIT) && (r_state[p] != S_ERR1);
            w_bad[p]  = (w_addr[p] >= PLEN'(MEM_BYTES)) || (w_size[p] > MAX_SIZE) ||
                        ((w_addr[p] & ((PLEN'(1) << w_size[p]) - PLEN'(1))) != '0) || w_inj[p];
            w_next[p] = w_acc[p] ? (w_bad[p] ? S_ERR1 : (w_wcfg[p] == '0 ? S_DATA : S_WAIT)) :
                        r_state[p] == S_WAIT ? (r_wcnt[p] == WAIT_W'(1) ? S_DATA : S_WAIT) :
                        r_state[p] == S_ERR1 ? S_ERR2 : S_IDLE;
            for (int b = 0; b < BW; b++)
                w_be[p][b] = (b >= int'(r_addr[p][AW-1:0])) &&
                             (b < int'(r_addr[p][AW-1:0]) + (1 << r_size[p]));
        end
    end

    // Per-port state register plus transfer attributes latched at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_state[p] <= S_IDLE;
                r_addr[p]  <= '0;
                r_write[p] <= 1'b0;
                r_size[p]  <= '0;
                r_wcnt[p]  <= '0;
                r_rdata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_state[p] <= w_next[p];
                if (w_acc[p]) begin
                    r_addr[p]  <= w_addr[p][MW-1:0];
                    r_write[p] <= HWRITE[p];
                    r_size[p]  <= w_size[p];
                    r_wcnt[p]  <= w_wcfg[p];
                end else if (r_state[p] == S_WAIT) begin
                    r_wcnt[p] <= r_wcnt[p] - WAIT_W'(1);
                end
                if (r_state[p] == S_DATA && !r_write[p])
                    r_rdata[p] <= w_word[p];
            end
        end
    end

    // Byte-lane writes in DATA; later ports overwrite earlier ones on shared lanes
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++)
            if (r_state[p] == S_DATA && r_write[p])
                for (int b = 0; b < BW; b++)
                    if (w_be[p][b])
                        r_mem[r_addr[p][MW-1:AW]][b*8 +: 8] <= HWDATA[p*XLEN + b*8 +: 8];
    end
endmodule

// File: tb/tb_riscv_ahb3_mem_responder.sv
// tb_riscv_ahb3_mem_responder: directed and randomized checks against a byte-array memory model.
module tb_riscv_ahb3_mem_responder;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] HSEL;
    logic [NP*64-1:0] HADDR, HWDATA, HRDATA;
    logic [NP-1:0] HWRITE, HREADY, HRESP, HMASTLOCK;
    logic [NP*3-1:0] HSIZE, HBURST;
    logic [NP*4-1:0] HPROT, wait_cfg;
    logic [NP*2-1:0] HTRANS;

    logic [7:0] mdl [4096];
    int n_assert = 0;
    int n_fail = 0;

    riscv_ahb3_mem_responder dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP), .wait_cfg(wait_cfg)
`ifdef AHB3_ERR_INJECT_EN
        , .err_inject('0)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mword(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mdl[{a[11:3], 3'b000} + i];
        return w;
    endfunction

    task automatic mwrite(input logic [63:0] a, input logic [2:0] sz, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) mdl[int'(a[11:0]) + i] = wd[8*((int'(a[2:0]) + i) % 8) +: 8];
    endtask

    task automatic setup(input int p, input bit wr, input logic [63:0] a, input logic [2:0] sz, input int wc);
        HSEL[p] = 1'b1;
        HTRANS[p*2 +: 2] = 2'b10;
        HADDR[p*64 +: 64] = a;
        HWRITE[p] = wr;
        HSIZE[p*3 +: 3] = sz;
        wait_cfg[p*4 +: 4] = 4'(wc);
    endtask

    task automatic idle(input int p);
        HSEL[p] = 1'b0;
        HTRANS[p*2 +: 2] = 2'b00;
    endtask

    task automatic xfer(input int p, input bit wr, input logic [63:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, input int wc, output logic [63:0] rd,
                        output int lowc, output logic rlow, output logic rfin);
        setup(p, wr, a, sz, wc);
        @(posedge clk); #1;
        idle(p);
        HWDATA[p*64 +: 64] = wd;
        lowc = 0;
        rlow = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (HREADY[p]) break;
            lowc++;
            rlow |= HRESP[p];
        end
        rd = HRDATA[p*64 +: 64];
        rfin = HRESP[p];
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input int p, input bit wr, input logic [63:0] a,
                       input logic [2:0] sz, input logic [63:0] wd, input int wc);
        bit err;
        logic [63:0] rd;
        int lowc;
        logic rlow, rfin;
        err = (a >= 64'd4096) || (sz > 3'd3) || (a % (64'd1 << sz) != 0);
        xfer(p, wr, a, sz, wd, wc, rd, lowc, rlow, rfin);
        chk({tag, ".wait"}, 64'(lowc), err ? 64'd1 : 64'(wc));
        chk({tag, ".resp"}, {62'd0, rlow, rfin}, err ? 64'd3 : 64'd0);
        if (!err && !wr) chk({tag, ".rdata"}, rd, mword(a));
        if (!err && wr) mwrite(a, sz, wd);
    endtask

    initial begin
        logic [63:0] ra, rw;
        rst = 1'b1;
        HSEL = '0; HADDR = '0; HWDATA = '0; HWRITE = '0; HSIZE = '0; HBURST = '0;
        HPROT = '0; HTRANS = '0; HMASTLOCK = '0; wait_cfg = '0;
        @(posedge clk); #1;
        chk("reset.hready", 64'(HREADY), 64'd3);
        chk("reset.hresp", 64'(HRESP), 64'd0);
        chk("reset.hrdata0", HRDATA[63:0], 64'd0);
        chk("reset.hrdata1", HRDATA[127:64], 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // back-to-back write then read of 0x100 on port 1, no wait states
        setup(1, 1'b1, 64'h100, 3'd3, 0);
        @(posedge clk); #1;
        HWDATA[127:64] = 64'h1122334455667788;
        HWRITE[1] = 1'b0;
        @(negedge clk);
        chk("b2b.rdy_wdata", 64'(HREADY[1]), 64'd1);
        @(posedge clk); #1;
        idle(1);
        mwrite(64'h100, 3'd3, 64'h1122334455667788);
        @(negedge clk);
        chk("b2b.rdy_rdata", 64'(HREADY[1]), 64'd1);
        chk("b2b.resp", 64'(HRESP[1]), 64'd0);
        chk("b2b.rdata", HRDATA[127:64], 64'h1122334455667788);
        @(posedge clk); #1;

        run("p0wait3", 0, 1'b0, 64'h100, 3'd3, 64'd0, 3);
        run("p1byte.w", 1, 1'b1, 64'h103, 3'd0, 64'hAB << 24, 0);
        run("p1byte.r", 1, 1'b0, 64'h100, 3'd3, 64'd0, 0);
        chk("p1byte.model", mword(64'h100), 64'h11223344AB667788);

        run("p0oob", 0, 1'b0, 64'h1000, 3'd3, 64'd0, 0);
        @(negedge clk);
        chk("p0oob.idle_rdy", 64'(HREADY[0]), 64'd1);
        chk("p0oob.idle_resp", 64'(HRESP[0]), 64'd0);
        @(posedge clk); #1;

        run("p1misal", 1, 1'b1, 64'h101, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run("p1misal.r", 1, 1'b0, 64'h100, 3'd3, 64'd0, 0);

        // both ports write 0x200 on the same edge
        setup(0, 1'b1, 64'h200, 3'd3, 0);
        setup(1, 1'b1, 64'h200, 3'd3, 0);
        @(posedge clk); #1;
        idle(0); idle(1);
        HWDATA[63:0] = 64'hAAAA_AAAA_AAAA_AAAA;
        HWDATA[127:64] = 64'h5555_5555_5555_5555;
        @(posedge clk); #1;
        mwrite(64'h200, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA);
        mwrite(64'h200, 3'd3, 64'h5555_5555_5555_5555);
        run("dual.r", 0, 1'b0, 64'h200, 3'd3, 64'd0, 0);
        chk("dual.model", mword(64'h200), 64'h5555_5555_5555_5555);

        // port 0 reads 0x200 while port 1 writes it on the same edge
        setup(0, 1'b0, 64'h200, 3'd3, 0);
        setup(1, 1'b1, 64'h200, 3'd3, 0);
        @(posedge clk); #1;
        idle(0); idle(1);
        HWDATA[127:64] = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("raw.old", HRDATA[63:0], 64'h5555_5555_5555_5555);
        @(posedge clk); #1;
        mwrite(64'h200, 3'd3, 64'h0123_4567_89AB_CDEF);
        run("raw.new", 0, 1'b0, 64'h200, 3'd3, 64'd0, 0);

        // reset during WAIT aborts a pending write
        run("rstw.pre", 1, 1'b1, 64'h300, 3'd3, 64'hCAFE_F00D_1234_5678, 0);
        setup(1, 1'b1, 64'h300, 3'd3, 5);
        @(posedge clk); #1;
        idle(1);
        HWDATA[127:64] = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        chk("rstw.waiting", 64'(HREADY[1]), 64'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rstw.rdy", 64'(HREADY[1]), 64'd1);
        chk("rstw.resp", 64'(HRESP[1]), 64'd0);
        chk("rstw.rdata", HRDATA[127:64], 64'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run("rstw.r", 1, 1'b0, 64'h300, 3'd3, 64'd0, 0);
        chk("rstw.model", mword(64'h300), 64'hCAFE_F00D_1234_5678);

        // randomized traffic over a pre-initialized region
        for (int i = 0; i < 32; i++)
            run($sformatf("init%0d", i), int'($urandom % 2), 1'b1, 64'h400 + 64'(i * 8), 3'd3,
                {$urandom, $urandom}, int'($urandom % 4));
        for (int i = 0; i < 80; i++) begin
            ra = ($urandom % 8 == 0) ? 64'h1000 + 64'($urandom % 64) : 64'h400 + 64'($urandom % 256);
            rw = {$urandom, $urandom};
            run($sformatf("rnd%0d", i), int'($urandom % 2), 1'($urandom % 2), ra, 3'($urandom % 5),
                rw, int'($urandom % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
